// File: rtl/fsk_symbol_gen.sv
// fsk_symbol_gen
// ---------------------------------------------------------------------------
// Purpose
//   Binary FSK symbol generator. Consumes the packet reader's symbol stream
//   (start/symVal), times every symbol over SYM_CYCLES clocks, returns a
//   one-clock symDone per symbol, and drives a phase-continuous NCO:
//   a frequency control word (fcw) plus a free-running phase accumulator
//   whose top PHASE_W bits feed the sine LUT / DAC stage.
//
// Optional feature
//   FSK_RAMP_EN : when defined, a tone change at a sample point walks fcw to
//                 the new tone over 2**RAMP_LOG2 clocks (RAMP state). When
//                 undefined, fcw steps in a single clock and the RAMP state
//                 and delta logic do not exist.
//
// Ports
//   clk        in   1        system clock, all logic on posedge
//   ready      in   1        synchronous active-low reset
//   start      in   1        transmit request (level-sensitive)
//   symVal     in   1        symbol bit, sampled only at sample points
//   symDone    out  1        one-clock registered pulse per symbol
//   tx_active  out  1        high while a symbol is being generated
//   sym_cur    out  1        symbol currently being transmitted
//   fcw        out  ACC_W    frequency control word in use, 0 when idle
//   phase      out  PHASE_W  top PHASE_W bits of the phase accumulator
//   fsm_state  out  2        debug view of the FSM state register
//
// Handshake
//   start is a level request. While start is high at a sample point
//   (IDLE, or sym_cnt == SYM_CYCLES-1) the edge captures symVal as the next
//   symbol. symDone is the acknowledgement: it is high for exactly one cycle
//   per symbol, in the cycle where sym_cnt == SYM_CYCLES-2, so the reader can
//   present the next bit before the following sample point. Dropping start
//   mid-symbol lets the current symbol (and its symDone) finish, then IDLE.
// ---------------------------------------------------------------------------
module fsk_symbol_gen #(
  parameter int               SYM_CYCLES = 16,
  parameter int               ACC_W      = 24,
  parameter int               PHASE_W    = 10,
  parameter logic [ACC_W-1:0] FCW_F0     = 24'h040000,
  parameter logic [ACC_W-1:0] FCW_F1     = 24'h060000
`ifdef FSK_RAMP_EN
  ,
  parameter int               RAMP_LOG2  = 2
`endif
) (
  input  logic               clk,
  input  logic               ready,
  input  logic               start,
  input  logic               symVal,
  output logic               symDone,
  output logic               tx_active,
  output logic               sym_cur,
  output logic [ACC_W-1:0]   fcw,
  output logic [PHASE_W-1:0] phase,
  output logic [1:0]         fsm_state
);

  localparam int CNT_W = $clog2(SYM_CYCLES);

  // Last count of a symbol (the sample point) and the count at which the
  // registered symDone is set so that it is visible at SYM_CYCLES-2.
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(SYM_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_DONE_SET = CNT_W'(SYM_CYCLES - 3);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYM  = 2'd1
`ifdef FSK_RAMP_EN
    ,
    ST_RAMP = 2'd2
`endif
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   sym_cnt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   new_fcw;
  logic               sample_pt;

`ifdef FSK_RAMP_EN
  localparam int RAMP_LEN = 1 << RAMP_LOG2;
  localparam int RAMP_CW  = (RAMP_LOG2 > 0) ? RAMP_LOG2 : 1;
  localparam logic [RAMP_CW-1:0] RAMP_LAST = RAMP_CW'(RAMP_LEN - 1);

  // fcw_tgt is the tone the current symbol settles on; during a ramp fcw
  // is an intermediate value, so tone-change detection uses fcw_tgt.
  logic [ACC_W-1:0]   fcw_tgt;
  logic signed [ACC_W:0] delta_new;
  logic signed [ACC_W:0] ramp_delta;
  logic [RAMP_CW-1:0] ramp_cnt;
  logic               tone_change;
`endif

  // -------------------------------------------------------------------------
  // Shared combinational helpers
  // -------------------------------------------------------------------------
  always_comb begin
    new_fcw   = symVal ? FCW_F1 : FCW_F0;
    sample_pt = (sym_cnt == CNT_LAST);
  end

`ifdef FSK_RAMP_EN
  // Signed step per ramp clock; one extra bit keeps the sign of the
  // difference of two unsigned words.
  always_comb begin
    tone_change = (new_fcw != fcw_tgt);
    delta_new   = ($signed({1'b0, new_fcw}) - $signed({1'b0, fcw_tgt})) >>> RAMP_LOG2;
  end
`endif

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!ready) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SYM;
      end
      ST_SYM: begin
        if (sample_pt) begin
          if (!start) begin
            state_d = ST_IDLE;
          end
`ifdef FSK_RAMP_EN
          else if (tone_change && (RAMP_LEN > 1)) begin
            state_d = ST_RAMP;
          end
`endif
        end
      end
`ifdef FSK_RAMP_EN
      ST_RAMP: begin
        if (ramp_cnt == RAMP_LAST) state_d = ST_SYM;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs derived directly from state / accumulator
  // -------------------------------------------------------------------------
  always_comb begin
    tx_active = (state_q != ST_IDLE);
    phase     = acc[ACC_W-1 -: PHASE_W];
    fsm_state = state_q;
  end

  // -------------------------------------------------------------------------
  // Datapath: symbol timer, tone registers, phase accumulator, symDone
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!ready) begin
      symDone <= 1'b0;
      sym_cur <= 1'b0;
      fcw     <= '0;
      acc     <= '0;
      sym_cnt <= '0;
`ifdef FSK_RAMP_EN
      fcw_tgt    <= '0;
      ramp_delta <= '0;
      ramp_cnt   <= '0;
`endif
    end else begin
      // Registered so the reader's edge-clocked counter sees a clean pulse.
      symDone <= (state_q != ST_IDLE) && (sym_cnt == CNT_DONE_SET);

      case (state_q)
        ST_IDLE: begin
          acc     <= '0;
          sym_cnt <= '0;
          if (start) begin
            sym_cur <= symVal;
            fcw     <= new_fcw;
`ifdef FSK_RAMP_EN
            fcw_tgt <= new_fcw;
`endif
          end
        end

        default: begin
          // Accumulator is never cleared at symbol boundaries: phase stays
          // continuous across tone changes. Wrap is modulo 2**ACC_W.
          acc <= acc + fcw;

          if (sample_pt) begin
            sym_cnt <= '0;
            if (start) begin
              sym_cur <= symVal;
`ifdef FSK_RAMP_EN
              fcw_tgt <= new_fcw;
              if (state_d == ST_RAMP) begin
                fcw        <= fcw_tgt + delta_new[ACC_W-1:0];
                ramp_delta <= delta_new;
                ramp_cnt   <= RAMP_CW'(1);
              end else begin
                fcw <= new_fcw;
              end
`else
              fcw <= new_fcw;
`endif
            end else begin
              fcw <= '0;
            end
          end else begin
            sym_cnt <= sym_cnt + CNT_W'(1);
`ifdef FSK_RAMP_EN
            // Last ramp clock lands exactly on the target, hiding any
            // truncation left over from the shifted delta.
            if (state_q == ST_RAMP) begin
              if (ramp_cnt == RAMP_LAST) begin
                fcw <= fcw_tgt;
              end else begin
                fcw      <= fcw + ramp_delta[ACC_W-1:0];
                ramp_cnt <= ramp_cnt + RAMP_CW'(1);
              end
            end
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_symbol_gen.sv
// tb_fsk_symbol_gen
// ---------------------------------------------------------------------------
// Bench for fsk_symbol_gen. Each test is planned as a list of per-clock
// input vectors plus the outputs expected right after that clock edge; the
// plan is then replayed against the DUT, popping one expectation per clock.
// A second instance with FCW_F1 = 24'h900000 covers accumulator wrap.
// ---------------------------------------------------------------------------
module tb_fsk_symbol_gen;

  localparam int               SYM_CYCLES = 16;
  localparam int               ACC_W      = 24;
  localparam int               PHASE_W    = 10;
  localparam logic [ACC_W-1:0] F0         = 24'h040000;
  localparam logic [ACC_W-1:0] F1         = 24'h060000;
  localparam logic [ACC_W-1:0] F1_WRAP    = 24'h900000;
  localparam int               RAMP_LOG2  = 2;
`ifdef FSK_RAMP_EN
  localparam int               RAMP_LEN   = 1 << RAMP_LOG2;
`else
  localparam int               RAMP_LEN   = 1;
`endif

  typedef logic [3+ACC_W+PHASE_W-1:0] exp_t;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic ready = 1'b0;
  logic start = 1'b0;
  logic sym_val = 1'b0;

  always #5 clk = ~clk;

  logic               sym_done, tx_active, sym_cur;
  logic [ACC_W-1:0]   fcw;
  logic [PHASE_W-1:0] phase;
  logic [1:0]         fsm_state;

  logic               w_done, w_active, w_cur;
  logic [ACC_W-1:0]   w_fcw;
  logic [PHASE_W-1:0] w_phase;
  logic [1:0]         w_state;

  fsk_symbol_gen #(
    .SYM_CYCLES(SYM_CYCLES), .ACC_W(ACC_W), .PHASE_W(PHASE_W),
    .FCW_F0(F0), .FCW_F1(F1)
  ) u_dut (
    .clk(clk), .ready(ready), .start(start), .symVal(sym_val),
    .symDone(sym_done), .tx_active(tx_active), .sym_cur(sym_cur),
    .fcw(fcw), .phase(phase), .fsm_state(fsm_state)
  );

  fsk_symbol_gen #(
    .SYM_CYCLES(SYM_CYCLES), .ACC_W(ACC_W), .PHASE_W(PHASE_W),
    .FCW_F0(F0), .FCW_F1(F1_WRAP)
  ) u_wrap (
    .clk(clk), .ready(ready), .start(start), .symVal(sym_val),
    .symDone(w_done), .tx_active(w_active), .sym_cur(w_cur),
    .fcw(w_fcw), .phase(w_phase), .fsm_state(w_state)
  );

  // ---------------------------------------------------------------- scoreboard
  exp_t       exp_q[$];
  logic [2:0] stim_q[$];   // {ready, start, symVal}
  int         checks = 0;
  int         errors = 0;

  logic [ACC_W-1:0] m_acc = '0;
  logic [ACC_W-1:0] m_fcw = '0;
  logic             m_cur = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t pack(input logic done, input logic act, input logic cur,
                                input logic [ACC_W-1:0] f, input logic [ACC_W-1:0] a);
    return {done, act, cur, f, a[ACC_W-1 -: PHASE_W]};
  endfunction

  function automatic logic [ACC_W-1:0] tone(input logic b);
    return b ? F1 : F0;
  endfunction

  function automatic logic rand_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // fcw expected k clocks into a symbol (k = sym_cnt after the edge).
  function automatic logic [ACC_W-1:0] fcw_at(input bit changed, input logic [ACC_W-1:0] old_t,
                                               input logic [ACC_W-1:0] new_t, input int k);
    int d;
    if (changed && (k < RAMP_LEN - 1)) begin
      d = (int'(new_t) - int'(old_t)) >>> RAMP_LOG2;
      return ACC_W'(int'(old_t) + (k + 1) * d);
    end
    return new_t;
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic push(input logic r, input logic s, input logic v, input exp_t e);
    stim_q.push_back({r, s, v});
    exp_q.push_back(e);
  endtask

  task automatic plan_reset(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b1, rand_bit(), pack(0, 0, 0, '0, '0));
    m_acc = '0; m_fcw = '0; m_cur = 1'b0;
  endtask

  task automatic plan_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b1, 1'b0, rand_bit(), pack(0, 0, m_cur, '0, '0));
    m_acc = '0; m_fcw = '0;
  endtask

  // n symbols from IDLE; start drops at count drop_cnt of the last symbol.
  // abort_at >= 0 asserts reset at that count of the first symbol instead.
  task automatic plan_stream(input logic [7:0] bits, input int n, input int drop_cnt,
                             input int abort_at);
    logic             st;
    logic             nb;
    logic [ACC_W-1:0] prev_t, cur_t;
    bit               changed;
    cur_t   = tone(bits[0]);
    prev_t  = cur_t;
    changed = 1'b0;
    m_cur   = bits[0];
    m_fcw   = cur_t;
    push(1'b1, 1'b1, bits[0], pack(0, 1, m_cur, m_fcw, '0));
    m_acc = '0;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < SYM_CYCLES; c++) begin
        if (c == abort_at) begin
          push(1'b0, 1'b1, rand_bit(), pack(0, 0, 0, '0, '0));
          m_acc = '0; m_fcw = '0; m_cur = 1'b0;
          return;
        end
        st    = !((i == n - 1) && (c >= drop_cnt));
        m_acc = m_acc + m_fcw;
        if (c < SYM_CYCLES - 1) begin
          m_fcw = fcw_at(changed, prev_t, cur_t, c + 1);
          push(1'b1, st, rand_bit(), pack(c + 1 == SYM_CYCLES - 2, 1, m_cur, m_fcw, m_acc));
        end else if (i < n - 1) begin
          nb      = bits[i+1];
          prev_t  = cur_t;
          cur_t   = tone(nb);
          changed = (prev_t != cur_t);
          m_cur   = nb;
          m_fcw   = fcw_at(changed, prev_t, cur_t, 0);
          push(1'b1, 1'b1, nb, pack(0, 1, m_cur, m_fcw, m_acc));
        end else begin
          m_fcw = '0;
          push(1'b1, 1'b0, rand_bit(), pack(0, 0, m_cur, '0, m_acc));
        end
      end
    end
  endtask

  // Replays the planned vectors; outputs are sampled 1 time unit after the edge.
  task automatic run_plan(input string name, input bit wrap_on, output int done_seen);
    logic [2:0]       s;
    exp_t             e;
    logic [ACC_W-1:0] wacc;
    int               idx;
    idx       = 0;
    done_seen = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      ready = s[2]; start = s[1]; sym_val = s[0];
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_eq($sformatf("%s[%0d]", name, idx), {sym_done, tx_active, sym_cur, fcw, phase}, e);
      if (sym_done) done_seen++;
      if (wrap_on && (idx == 1 || idx == 2)) begin
        wacc = (idx == 1) ? F1_WRAP : F1_WRAP + F1_WRAP;
        check_eq($sformatf("wrap_phase[%0d]", idx), w_phase, wacc[ACC_W-1 -: PHASE_W]);
      end
      idx++;
    end
  endtask

  // ---------------------------------------------------------------- tests
  initial begin
    int         dn;
    logic [7:0] rbits;

    // Reset held with start high: everything stays quiet.
    plan_reset(3);
    run_plan("reset", 1'b0, dn);
    check_eq("reset_done_count", dn, 0);
    plan_idle(2);
    run_plan("idle0", 1'b0, dn);

    // Single 1-symbol, start dropped at count 5; wrap instance checked alongside.
    plan_stream(8'b0000_0001, 1, 5, -1);
    run_plan("single", 1'b1, dn);
    check_eq("single_done_count", dn, 1);
    plan_idle(2);
    run_plan("idle1", 1'b0, dn);

    // Stream 1,0,1,1 with start held until the last symbol.
    plan_stream(8'b0000_1101, 4, 5, -1);
    run_plan("stream", 1'b0, dn);
    check_eq("stream_done_count", dn, 4);
    plan_idle(2);
    run_plan("idle2", 1'b0, dn);

    // Abort at sym_cnt 7, then a fresh symbol straight after release.
    plan_stream(8'b0000_0001, 1, SYM_CYCLES, 7);
    run_plan("abort", 1'b0, dn);
    check_eq("abort_done_count", dn, 0);
    plan_stream(8'b0000_0000, 1, 5, -1);
    run_plan("fresh", 1'b0, dn);
    check_eq("fresh_done_count", dn, 1);
    plan_idle(2);
    run_plan("idle3", 1'b0, dn);

    // Random 6-symbol stream.
    rbits = 8'($urandom_range(0, 63));
    plan_stream(rbits, 6, 3, -1);
    run_plan("random", 1'b0, dn);
    check_eq("random_done_count", dn, 6);
    plan_idle(2);
    run_plan("idle4", 1'b0, dn);

    check_eq("queue_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
